// File: rtl/signal_switch_ctrl_pkg.sv
// Shared types and default parameters for the signal switch control stage.
package signal_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_BLANK,
    ST_SETTLE
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_DEAD_CYCLES     = 2;
  localparam int DEF_CNT_W           = 8;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/signal_switch_ctrl_if.sv
// Request/status bundle between the switch controller and its client.
interface signal_switch_ctrl_if
  import signal_switch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             req_sel;
  logic             force_a;
  logic             sel;
  logic             out_en;
  logic             busy;
  logic             sw_done;
  logic [CNT_W-1:0] sw_count;

  modport master (
    output req_sel, force_a,
    input  sel, out_en, busy, sw_done, sw_count
  );

  modport slave (
    input  req_sel, force_a,
    output sel, out_en, busy, sw_done, sw_count
  );

endinterface

// File: rtl/signal_switch_ctrl_sw_tick_counter.sv
// Loadable down-counter with a zero flag; used for debounce and dead-time.
module sw_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge values.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/signal_switch_ctrl.sv
// Debounced, break-before-make select control for a 2:1 signal mux.
module signal_switch_ctrl
  import signal_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DEAD_CYCLES     = DEF_DEAD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  signal_switch_ctrl_if.slave bus
);

  // The IDLE->DEBOUNCE edge already counts as the first sample, and the
  // completing edge sees zero, so the debounce counter is loaded with N-2.
  localparam int DB_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam int DT_W      = cnt_width(DEAD_CYCLES);
  localparam int DB_LOAD   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam int DEAD_LOAD = DEAD_CYCLES - 1;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             pend_q, pend_d;
  logic             real_q, real_d;
  logic             out_en_q, out_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic db_load, db_dec, db_zero;
  logic dt_load, dt_dec, dt_zero;
  logic target;

  assign target = bus.force_a ? 1'b0 : bus.req_sel;

  sw_tick_counter #(.W(DB_W)) u_db_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (db_load),
    .load_val_i (DB_W'(DB_LOAD)),
    .dec_i      (db_dec),
    .zero_o     (db_zero)
  );

  sw_tick_counter #(.W(DT_W)) u_dead_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dt_load),
    .load_val_i (DT_W'(DEAD_LOAD)),
    .dec_i      (dt_dec),
    .zero_o     (dt_zero)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    real_d  = real_q;
    done_d  = 1'b0;
    count_d = count_q;
    db_load = 1'b0;
    db_dec  = 1'b0;
    dt_load = 1'b0;
    dt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.force_a && sel_q) begin
          state_d = ST_BLANK;
          pend_d  = 1'b0;
          dt_load = 1'b1;
        end else if (target != sel_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_BLANK;
            pend_d  = target;
            dt_load = 1'b1;
          end else begin
            state_d = ST_DEBOUNCE;
            db_load = 1'b1;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (target == sel_q) begin
          state_d = ST_IDLE;
        end else if (bus.force_a && sel_q) begin
          state_d = ST_BLANK;
          pend_d  = 1'b0;
          dt_load = 1'b1;
        end else if (db_zero) begin
          state_d = ST_BLANK;
          pend_d  = target;
          dt_load = 1'b1;
        end else begin
          db_dec = 1'b1;
        end
      end

      ST_BLANK: begin
        // A force on the exit edge still wins, so it is applied first.
        if (bus.force_a) pend_d = 1'b0;
        if (dt_zero) begin
          sel_d   = pend_d;
          real_d  = (pend_d != sel_q);
          state_d = ST_SETTLE;
          dt_load = 1'b1;
        end else begin
          dt_dec = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (dt_zero) begin
          state_d = ST_IDLE;
          if (real_q) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          dt_dec = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_en_d = (state_d == ST_IDLE) || (state_d == ST_DEBOUNCE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset returns the mux to IN_A immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      pend_q   <= 1'b0;
      real_q   <= 1'b0;
      out_en_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      real_q   <= real_d;
      out_en_q <= out_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.out_en   = out_en_q;
  assign bus.busy     = busy_q;
  assign bus.sw_done  = done_q;
  assign bus.sw_count = count_q;

endmodule

// File: tb/tb_signal_switch_ctrl.sv
// Self-checking bench: directed timing checks plus a scoreboard of expected
// switch completions, popped whenever a DUT raises its done pulse.
module tb_signal_switch_ctrl;
  import signal_switch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signal_switch_ctrl_if #(.CNT_W(8)) bus ();
  signal_switch_ctrl_if #(.CNT_W(2)) bus_w ();

  signal_switch_ctrl #(.DEBOUNCE_CYCLES(4), .DEAD_CYCLES(2), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  signal_switch_ctrl #(.DEBOUNCE_CYCLES(4), .DEAD_CYCLES(2), .CNT_W(2)) dut_w (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_w)
  );

  typedef struct {
    logic sel;
    int   count;
  } exp_t;

  exp_t sb_q[$];
  exp_t sbw_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitors: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst && bus.sw_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_sw_done", bus.sw_done, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_sel", bus.sel, e.sel);
        check("done_count", bus.sw_count, e.count);
      end
    end
  end

  always @(negedge clk) begin : mon_wrap
    exp_t e;
    if (!rst && bus_w.sw_done) begin
      if (sbw_q.size() == 0) begin
        check("wrap_unexpected_sw_done", bus_w.sw_done, 0);
      end else begin
        e = sbw_q.pop_front();
        check("wrap_done_sel", bus_w.sel, e.sel);
        check("wrap_done_count", bus_w.sw_count, e.count);
      end
    end
  end

  initial begin
    logic [8:0] oe_tbl;
    logic [8:0] sel_tbl;
    logic [8:0] done_tbl;
    logic       r;

    rst           = 1'b1;
    bus.req_sel   = 1'b0;
    bus.force_a   = 1'b0;
    bus_w.req_sel = 1'b0;
    bus_w.force_a = 1'b0;

    // Reset then idle.
    step();
    step();
    check("rst_sel", bus.sel, 0);
    check("rst_out_en", bus.out_en, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_sw_done", bus.sw_done, 0);
    check("rst_sw_count", bus.sw_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_sel", bus.sel, 0);
      check("idle_out_en", bus.out_en, 1);
      check("idle_busy", bus.busy, 0);
    end
    check("idle_sw_count", bus.sw_count, 0);

    // Bounce: request high for three edges, dropped on the completing edge.
    bus.req_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bounce_out_en", bus.out_en, 1);
      check("bounce_busy", bus.busy, 1);
    end
    bus.req_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bounce_out_en_after", bus.out_en, 1);
      check("bounce_busy_after", bus.busy, 0);
      check("bounce_sel", bus.sel, 0);
    end
    check("bounce_sw_count", bus.sw_count, 0);

    // Normal 0->1 switch: BLANK after edge 3, SEL after edge 5, done after edge 7.
    oe_tbl   = 9'b110000111;
    sel_tbl  = 9'b111100000;
    done_tbl = 9'b010000000;
    bus.req_sel = 1'b1;
    sb_q.push_back('{sel: 1'b1, count: 1});
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("norm_out_en_e%0d", i), bus.out_en, oe_tbl[i]);
      check($sformatf("norm_sel_e%0d", i), bus.sel, sel_tbl[i]);
      check($sformatf("norm_sw_done_e%0d", i), bus.sw_done, done_tbl[i]);
    end
    check("norm_sw_count", bus.sw_count, 1);
    check("norm_busy", bus.busy, 0);

    // Force back to IN_A from idle with SEL=1, bypassing debounce.
    bus.force_a = 1'b1;
    bus.req_sel = 1'b0;
    sb_q.push_back('{sel: 1'b0, count: 2});
    step();
    check("force_out_en_e0", bus.out_en, 0);
    check("force_busy_e0", bus.busy, 1);
    bus.force_a = 1'b0;
    step();
    check("force_sel_e1", bus.sel, 1);
    step();
    check("force_sel_e2", bus.sel, 0);
    check("force_out_en_e2", bus.out_en, 0);
    step();
    check("force_out_en_e3", bus.out_en, 0);
    step();
    check("force_out_en_e4", bus.out_en, 1);
    check("force_sw_done_e4", bus.sw_done, 1);
    check("force_sw_count", bus.sw_count, 2);
    check("force_busy_e4", bus.busy, 0);

    // Force during BLANK of a 0->1 switch cancels it: no SEL change, no count.
    bus.req_sel = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("fblank_out_en_e3", bus.out_en, 0);
    bus.force_a = 1'b1;
    bus.req_sel = 1'b0;
    step();
    bus.force_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fblank_sel", bus.sel, 0);
      check("fblank_sw_done", bus.sw_done, 0);
    end
    check("fblank_out_en", bus.out_en, 1);
    check("fblank_busy", bus.busy, 0);
    check("fblank_sw_count", bus.sw_count, 2);

    // Reset in the middle of SETTLE with SEL already at 1.
    bus.req_sel = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("midrst_pre_sel", bus.sel, 1);
    check("midrst_pre_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    check("midrst_sel", bus.sel, 0);
    check("midrst_out_en", bus.out_en, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_sw_done", bus.sw_done, 0);
    check("midrst_sw_count", bus.sw_count, 0);
    bus.req_sel = 1'b0;
    rst = 1'b0;
    step();
    check("midrst_idle_sel", bus.sel, 0);

    // Counter wrap on a 2-bit instance: 1,2,3,0,1.
    r = 1'b0;
    for (int k = 0; k < 5; k++) begin
      r = ~r;
      bus_w.req_sel = r;
      sbw_q.push_back('{sel: r, count: (k + 1) % 4});
      for (int i = 0; i < 10; i++) step();
      check($sformatf("wrap_count_%0d", k), bus_w.sw_count, (k + 1) % 4);
      check($sformatf("wrap_sel_%0d", k), bus_w.sel, r);
    end

    step();
    check("sb_empty", sb_q.size(), 0);
    check("sbw_empty", sbw_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
